// File: rtl/irq_pkg.sv
// Shared constants for the interrupt debounce/latch block.
package irq_pkg;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_BOTH    = 2;

    localparam int MAX_INPUTS   = 16;

endpackage

// File: rtl/debounce_channel.sv
// One external line: two-flop synchroniser, tick-driven debounce counter,
// accepted level and single-cycle rise/fall event outputs.
module debounce_channel
    import irq_pkg::*;
#(
    parameter int STABLE_SAMPLES = 3
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_ext,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CW       = $clog2(STABLE_SAMPLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // The final disagreeing sample both flips the level and fires the event.
    assign w_accept = i_tick && (r_s2 != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= i_ext;
            r_s2 <= r_s1;
            if (i_tick) begin
                if (r_s2 == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_accept &  r_s2;
    assign o_fall  = w_accept & ~r_s2;

endmodule

// File: rtl/irq_debounce_latch.sv
// Debounces NUM_INPUTS external lines on sample_clk ticks, latches the selected
// edge as a pending interrupt until acked, and reports the lowest pending index.
module irq_debounce_latch
    import irq_pkg::*;
#(
    parameter  int NUM_INPUTS     = 4,
    parameter  int STABLE_SAMPLES = 3,
    parameter  int EDGE_MODE      = EDGE_RISING,
    localparam int IDW            = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_clk,
    input  logic [NUM_INPUTS-1:0] ext_in,
    input  logic [NUM_INPUTS-1:0] irq_ack,
    output logic [NUM_INPUTS-1:0] btn_level,
    output logic [NUM_INPUTS-1:0] irq_pending,
    output logic                  irq,
    output logic [IDW-1:0]        irq_id
);

    logic                  r_sample_q;
    logic                  w_tick;
    logic [NUM_INPUTS-1:0] w_rise;
    logic [NUM_INPUTS-1:0] w_fall;
    logic [NUM_INPUTS-1:0] w_event;
    logic [NUM_INPUTS-1:0] r_pending;
    logic [IDW-1:0]        w_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample_q <= 1'b0;
        end else begin
            r_sample_q <= sample_clk;
        end
    end

    assign w_tick = sample_clk & ~r_sample_q;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_ext   (ext_in[g]),
            .o_level (btn_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    assign w_event = (w_rise & {NUM_INPUTS{EDGE_MODE != EDGE_FALLING}})
                   | (w_fall & {NUM_INPUTS{EDGE_MODE != EDGE_RISING}});

    // Set after clear so an event coinciding with its own ack is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~irq_ack) | w_event;
        end
    end

    always_comb begin
        w_id = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_id = IDW'(i);
            end
        end
    end

    assign irq_pending = r_pending;
    assign irq         = |r_pending;
    assign irq_id      = w_id;

endmodule

// File: doc/irq_debounce_latch.md
Name: irq_debounce_latch

Overview:
- Sits directly downstream of clock_divider.
- Consumes its slow out_clk as a sampling strobe, and synchronises and debounces NUM_INPUTS asynchronous external interrupt lines (buttons/pins).
- Detects the configured edge on each debounced line and latches it as a pending interrupt. The pending bit holds until the consumer acknowledges it.
- Outputs feed the interrupt-handling logic: a pending vector, an OR'd irq, and a lowest-index-first irq_id.

Parameters:
- NUM_INPUTS, 4: number of external interrupt lines (1..16).
- STABLE_SAMPLES, 3: consecutive sample ticks a new level must persist before it is accepted (2..15).
- EDGE_MODE, 0: 0 = rising, 1 = falling, 2 = both edges raise an interrupt.

Ports:
- clk  in  1  system clock; same clock that drives clock_divider.
- rst  in  1  asynchronous, active-low reset.
- sample_clk  in  1  out_clk from clock_divider; a registered level in the clk domain.
- ext_in  in  NUM_INPUTS  raw external lines; asynchronous to clk.
- irq_ack  in  NUM_INPUTS  one-hot-or-multi clear strobes, one clk wide.
- btn_level  out  NUM_INPUTS  debounced level per line.
- irq_pending  out  NUM_INPUTS  latched pending flags.
- irq  out  1  OR of irq_pending.
- irq_id  out  $clog2(NUM_INPUTS)  index of the lowest set pending bit; 0 when none.

Behaviour:
- Reset (rst=0, async): every sync flop, sample_q, debounce counter, btn_level and irq_pending clear to 0. Therefore irq=0 and irq_id=0. This applies mid-operation too: an in-progress debounce is discarded.
- Tick generation:
  - sample_q <= sample_clk each clk.
  - tick = sample_clk & ~sample_q, i.e. one clk wide on each rising edge of sample_clk.
  - With divider DEF_FREQ=F, one tick occurs per F clk cycles.
- Synchroniser: two flops per line (s1, s2). Only s2 is used downstream.
- Debounce per line (state only changes on tick):
  - s2 == btn_level: cnt <= 0.
  - s2 != btn_level and cnt < STABLE_SAMPLES-1: cnt <= cnt+1.
  - s2 != btn_level and cnt == STABLE_SAMPLES-1: btn_level <= s2, cnt <= 0.
  - Any single matching sample restarts the count (glitch rejection).
  - cnt width is $clog2(STABLE_SAMPLES); cnt never wraps.
- Edge event: generated in the same clk cycle that btn_level updates. Rising = 0->1, falling = 1->0, per EDGE_MODE.
- Pending:
  - On an event, irq_pending[i] <= 1.
  - On irq_ack[i]=1, irq_pending[i] <= 0.
  - Event and ack in the same cycle: set wins, pending stays 1, so no event is lost.
  - Ack on a clear bit has no effect.
  - Repeated events while pending do not count; the bit stays 1.
- irq and irq_id are combinational from the irq_pending registers; no added latency.
- Latency from a stable ext_in change to irq_pending=1:
  - 2 clk for synchronisation, then STABLE_SAMPLES ticks.
  - Pending sets in the clk of the final tick.
- btn_level is never X: sync flops are reset.

Decomposition:
- Package irq_pkg: EDGE_RISING=0, EDGE_FALLING=1, EDGE_BOTH=2 localparams; max NUM_INPUTS constant.
- Sub-module debounce_channel: per line, holds the 2-flop sync, counter, level and edge event output. It is instantiated NUM_INPUTS times via generate.
- Top-level block: tick generation, pending register, priority encoder.

Test Plan:
- Bench setup: clock_divider DEF_FREQ=8 drives sample_clk, giving a tick every 8 clk.
- Reset: hold rst=0 for 5 clk with ext_in toggling -> all outputs 0; release -> outputs still 0 until a debounce completes.
- Clean press: NUM_INPUTS=4, STABLE_SAMPLES=3, EDGE_MODE=0; ext_in[2] 0->1 held -> btn_level[2]=1 and irq_pending=4'b0100 on the 3rd tick after sync; irq=1, irq_id=2.
- Glitch: ext_in[1] high for 2 ticks then low for 1 tick, then high 3 ticks -> no pending until the 3rd consecutive high tick; exactly one set.
- Priority/ack: pending 4'b1010 -> irq_id=1; pulse irq_ack=4'b0010 -> pending=4'b1000, irq_id=3; ack 4'b1000 -> irq=0, irq_id=0.
- Set-vs-ack collision: ack[0] asserted in the exact clk that line 0's level updates -> irq_pending[0]=1 afterwards.
- EDGE_MODE=2 and mid-op reset:
  - Press then release line 0 -> two events; ack between them gives two set pulses.
  - Assert rst after 2 of 3 stable ticks -> after release, a full 3 fresh ticks are required.
